// File: rtl/mem_block_responder.sv
// Block-granular memory responder: accepts one read/write request at a time
// and answers it a fixed LATENCY edges later with the block contents.
module mem_block_responder #(
    parameter int unsigned ADDR_SIZE  = 10,
    parameter int unsigned BLOCK_SIZE = 128,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_row,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    input  logic [BLOCK_SIZE-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BLOCK_SIZE-1:0] resp_rdata,
    input  logic [ADDR_SIZE-5:0]  dbg_idx,
    output logic [BLOCK_SIZE-1:0] dbg_data
);

    localparam int unsigned IDX_W = ADDR_SIZE - 4;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  row_q, row_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
    logic [BLOCK_SIZE-1:0] rdata_d;
    logic                  req_ready_d, resp_valid_d;
    logic                  we;
    logic [BLOCK_SIZE-1:0] mem [DEPTH];

    // Byte offset within a block carries no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[3:0];

    assign dbg_data = mem[dbg_idx];

    // Next-state, request capture and access decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = resp_rdata;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    row_d   = req_row;
                    idx_d   = req_addr[ADDR_SIZE-1:4];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    we      = row_q;
                    rdata_d = row_q ? wdata_q : mem[idx_q];
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            resp_rdata <= rdata_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
        end
    end

    // Storage; reset wipes every block so an aborted write leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: directed scenarios plus random transactions
// compared against an array model; a second LATENCY=1 instance checks pacing.
module tb_mem_block_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_row, resp_valid, resp_ready;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata, resp_rdata, dbg_data;
    logic [5:0]   dbg_idx;

    logic         r1_valid, r1_ready, r1_row, p1_valid, p1_ready;
    logic [9:0]   r1_addr;
    logic [127:0] r1_wdata, p1_rdata, d1_data;
    logic [5:0]   d1_idx;

    logic [127:0] model [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_block_responder #(.ADDR_SIZE(10), .BLOCK_SIZE(128), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    mem_block_responder #(.ADDR_SIZE(10), .BLOCK_SIZE(128), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_row(r1_row),
        .req_addr(r1_addr), .req_wdata(r1_wdata),
        .resp_valid(p1_valid), .resp_ready(p1_ready), .resp_rdata(p1_rdata),
        .dbg_idx(d1_idx), .dbg_data(d1_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble_req(input logic vld);
        req_valid = vld;
        req_row   = 1'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = rnd128();
    endtask

    // One full transaction on the LATENCY=4 instance, checked against the model.
    task automatic txn(input logic row, input logic [9:0] addr, input logic [127:0] wd,
                       input int hold);
        logic [5:0]   idx;
        logic [127:0] old, exp;
        int n;
        idx = addr[9:4];
        old = model[idx];
        exp = row ? wd : old;
        chk("idle_ready", {127'b0, req_ready}, 128'd1);
        dbg_idx   = idx;
        req_valid = 1'b1;
        req_row   = row;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        chk("access_ready", {127'b0, req_ready}, 128'd0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin
            if (n == LAT - 1) chk("dbg_before_commit", dbg_data, old);
            scramble_req(1'($urandom));
            tick();
            n++;
        end
        chk("latency", 128'(n), 128'(LAT));
        if (row) model[idx] = wd;
        chk("rdata", resp_rdata, exp);
        chk("dbg_after_commit", dbg_data, model[idx]);
        for (int h = 0; h < hold; h++) begin
            scramble_req(1'($urandom));
            tick();
            chk("hold_valid", {127'b0, resp_valid}, 128'd1);
            chk("hold_rdata", resp_rdata, exp);
            chk("hold_ready", {127'b0, req_ready}, 128'd0);
        end
        scramble_req(1'b1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("leave_valid", {127'b0, resp_valid}, 128'd0);
        chk("no_accept_on_leave", {127'b0, req_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] pat_a, w1, w2;
        logic [9:0]   a1, addr;
        for (int i = 0; i < 64; i++) model[i] = '0;
        rst_n = 1'b0;
        req_valid = 1'b1; req_row = 1'b1; req_addr = '0; req_wdata = '1;
        resp_ready = 1'b0; dbg_idx = '0;
        r1_valid = 1'b0; r1_row = 1'b0; r1_addr = '0; r1_wdata = '0;
        p1_ready = 1'b0; d1_idx = '0;
        #1;
        chk("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("rst_rdata", resp_rdata, 128'd0);
        tick();
        tick();
        chk("rst_req_ready", {127'b0, req_ready}, 128'd1);
        chk("rst_dbg0", dbg_data, 128'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {127'b0, req_ready}, 128'd1);

        txn(1'b0, 10'h000, rnd128(), 0);
        txn(1'b1, 10'h000, 128'hFF, 0);
        txn(1'b0, 10'h00F, rnd128(), 0);
        pat_a = 128'hA5A5_5A5A_0123_4567_89AB_CDEF_DEAD_BEEF;
        txn(1'b1, 10'h200, pat_a, 1);
        txn(1'b0, 10'h200, rnd128(), 0);
        txn(1'b0, 10'h000, rnd128(), 0);
        txn(1'b0, 10'h200, rnd128(), 10);

        // Reset in the middle of a write access to block 48.
        req_valid = 1'b1; req_row = 1'b1; req_addr = 10'h300; req_wdata = rnd128();
        dbg_idx = 6'd48;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {127'b0, resp_valid}, 128'd0);
        chk("abort_rdata", resp_rdata, 128'd0);
        for (int i = 0; i < 64; i++) model[i] = '0;
        tick();
        rst_n = 1'b1;
        chk("abort_dbg48", dbg_data, 128'd0);
        dbg_idx = 6'd0;
        #1;
        chk("abort_dbg0", dbg_data, 128'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_resp", {127'b0, resp_valid}, 128'd0);
        end

        // LATENCY=1 instance: write then read, both held valid with resp_ready=1.
        a1 = 10'($urandom);
        w1 = rnd128();
        w2 = rnd128();
        d1_idx = a1[9:4];
        p1_ready = 1'b1;
        r1_valid = 1'b1; r1_row = 1'b1; r1_addr = a1; r1_wdata = w1;
        tick();
        chk("l1_accept_ready", {127'b0, r1_ready}, 128'd0);
        chk("l1_accept_valid", {127'b0, p1_valid}, 128'd0);
        r1_row = 1'b0; r1_wdata = w2;
        tick();
        chk("l1_wr_valid", {127'b0, p1_valid}, 128'd1);
        chk("l1_wr_rdata", p1_rdata, w1);
        chk("l1_dbg", d1_data, w1);
        tick();
        chk("l1_gap_ready", {127'b0, r1_ready}, 128'd1);
        chk("l1_gap_valid", {127'b0, p1_valid}, 128'd0);
        tick();
        chk("l1_rd_accept", {127'b0, r1_ready}, 128'd0);
        r1_valid = 1'b0;
        tick();
        chk("l1_rd_valid", {127'b0, p1_valid}, 128'd1);
        chk("l1_rd_rdata", p1_rdata, w1);
        tick();
        chk("l1_end_idle", {127'b0, r1_ready}, 128'd1);
        p1_ready = 1'b0;

        // Random traffic, biased toward a few blocks so reads hit earlier writes.
        for (int t = 0; t < 40; t++) begin
            addr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 127)) : 10'($urandom);
            txn(1'($urandom), addr, rnd128(), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 10, byte-address width.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 128, bits per block transfer (16 bytes).
REQ-003 The block SHALL have parameter LATENCY, default 4, cycles from request acceptance to response (legal range 1..15).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid  input  1  requester presents a request.
REQ-007 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 The block SHALL have port req_row  input  1  access type: 0 read, 1 write.
REQ-009 The block SHALL have port req_addr  input  ADDR_SIZE  byte address; bits [ADDR_SIZE-1:4] select the block, bits [3:0] are ignored.
REQ-010 The block SHALL have port req_wdata  input  BLOCK_SIZE  full block to write.
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  requester consumes the response.
REQ-013 The block SHALL have port resp_rdata  output  BLOCK_SIZE  block contents after the access.
REQ-014 The block SHALL have port dbg_idx  input  ADDR_SIZE-4  block index for content inspection.
REQ-015 The block SHALL have port dbg_data  output  BLOCK_SIZE  combinational view of storage[dbg_idx].

Function
REQ-016 Storage SHALL be 2^(ADDR_SIZE-4) blocks of BLOCK_SIZE bits (64 blocks at defaults).
REQ-017 FSM states SHALL be IDLE, ACCESS and RESP; req_ready=1 only in IDLE, resp_valid=1 only in RESP.
REQ-018 IDLE: an edge with req_valid=1 SHALL latch req_row, block index and req_wdata, load the counter with LATENCY-1, and enter ACCESS.
REQ-019 req_* inputs SHALL be ignored outside the accepting edge; changes during ACCESS/RESP SHALL have no effect.
REQ-020 ACCESS: the counter SHALL decrement each edge; the edge with counter==0 SHALL perform the access and enter RESP, so resp_valid rises exactly LATENCY edges after the accepting edge.
REQ-021 Read access SHALL load resp_rdata with storage[index]; storage SHALL be unchanged.
REQ-022 Write access SHALL write latched wdata to storage[index] and load resp_rdata with that same wdata.
REQ-023 RESP: resp_rdata SHALL hold stable; an edge with resp_ready=1 SHALL return to IDLE with resp_valid=0; otherwise RESP SHALL persist indefinitely.
REQ-024 A new request SHALL NOT be accepted on the edge leaving RESP; earliest acceptance is the following edge (one IDLE cycle minimum between transactions).
REQ-025 dbg_data SHALL reflect storage combinationally; a dbg_idx equal to a block being written SHALL show old data until the committing edge, new data after.
REQ-026 Back-to-back accesses to the same block SHALL observe each other in order (a read following a write returns the written data).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, resp_valid=0, resp_rdata=0, req_ready=1 after release, and clear all storage blocks to 0.
REQ-028 Reset asserted during ACCESS or RESP SHALL abort the transaction; no write SHALL be committed.
REQ-029 The first request SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-030 Reset then read addr 0x000 -> resp_valid at edge 4 after acceptance, resp_rdata=0, dbg_data[idx 0]=0.
REQ-031 Write addr 0x000, wdata low byte 0xFF (rest 0) -> after commit dbg_idx=0 shows 0x...FF; subsequent read addr 0x00F returns same block.
REQ-032 Write addr 0x200 pattern A, then read 0x200 and 0x000 -> returns A and the 0xFF block respectively; block 32 and block 0 independent.
REQ-033 Hold resp_ready=0 for 10 cycles in RESP while toggling req_* -> resp_valid and resp_rdata stable, req_ready=0, no second acceptance.
REQ-034 Assert rst_n=0 at cycle 2 of a write ACCESS to addr 0x300 -> resp_valid never rises, dbg_data[idx 48]=0 after reset.
REQ-035 LATENCY=1 build: accept read -> resp_valid on the very next edge; resp_ready held 1 -> one IDLE cycle between consecutive transactions.
